// File: rtl/bus_txn_scheduler.sv
// ============================================================================
// Module   : bus_txn_scheduler
// Purpose  : Round-robin bus arbiter for three requesters (io, L2 cache,
//            uncached). A winner is chosen in IDLE, confirmed in GRANT, owns
//            the bus in HOLD until it frees it or the hold timer expires,
//            and a one-cycle GAP always separates consecutive owners.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_txn_scheduler #(
  parameter int N_REQ   = 3,
  parameter int WN_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WN_W-1:0]   req_words,
  input  logic [N_REQ-1:0]        free,
  output logic [N_REQ-1:0]        grant,
  output logic [WN_W-1:0]         word_number,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [1:0]              err_id
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  c_idle  = 2'd0;
  localparam logic [1:0]  c_grant = 2'd1;
  localparam logic [1:0]  c_hold  = 2'd2;
  localparam logic [1:0]  c_gap   = 2'd3;

  localparam int          c_cnt_w = 16;
  // Last HOLD cycle index: HOLD lasts TIMEOUT cycles when nobody frees.
  localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(TIMEOUT - 1);
  localparam logic [2:0]  c_nreq  = 3'(N_REQ);
  // After reset the search starts just past this index, so io wins first.
  localparam logic [1:0]  c_last_rst = 2'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [1:0]          r_last_owner;
  logic [1:0]          r_winner;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [N_REQ-1:0]    r_grant;
  logic                r_busy;
  logic [WN_W-1:0]     r_word_number;
  logic                r_timeout_err;
  logic [1:0]          r_err_id;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0]    w_eligible;
  logic                w_any;
  logic [1:0]          w_winner;
  logic [N_REQ-1:0]    w_win_onehot;
  logic [WN_W-1:0]     w_win_words;
  logic                w_owner_free;
  logic                w_term;

  // Index of the k-th candidate in the round-robin search after `last`.
  function automatic logic [1:0] rr_idx(input logic [1:0] last,
                                        input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, last} + 3'd1 + {1'b0, k};
    if (s >= c_nreq) s = s - c_nreq;
    if (s >= c_nreq) s = s - c_nreq;
    return s[1:0];
  endfunction

  // A requester with a zero word count can never be chosen.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
      assign w_eligible[gi] = req[gi] && (req_words[gi*WN_W +: WN_W] != '0);
    end
  endgenerate

  // Round-robin pick: walk candidates from farthest to nearest so the
  // nearest eligible one (highest priority) is the final assignment.
  always_comb begin
    w_any    = 1'b0;
    w_winner = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_eligible[rr_idx(r_last_owner, 2'(k))]) begin
        w_any    = 1'b1;
        w_winner = rr_idx(r_last_owner, 2'(k));
      end
    end
  end

  // Decode the registered winner into its one-hot grant and word count.
  always_comb begin
    w_win_onehot = '0;
    w_win_words  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_win_onehot[i] = (r_winner == 2'(i));
      if (r_winner == 2'(i)) begin
        w_win_words = req_words[i*WN_W +: WN_W];
      end
    end
  end

  // The grant vector is one-hot on the owner, so masking free with it
  // ignores pulses from anyone else and is zero outside HOLD.
  assign w_owner_free = |(free & r_grant);
  assign w_term       = (r_cnt == c_term);

  // Arbitration FSM with registered grant/busy/word count/error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_idle;
      r_last_owner  <= c_last_rst;
      r_winner      <= 2'd0;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_word_number <= '0;
      r_timeout_err <= 1'b0;
      r_err_id      <= 2'd0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_any) begin
            r_winner <= w_winner;
            r_state  <= c_grant;
          end
        end
        c_grant: begin
          r_last_owner  <= r_winner;
          r_word_number <= w_win_words;
          r_grant       <= w_win_onehot;
          r_busy        <= 1'b1;
          r_state       <= c_hold;
        end
        c_hold: begin
          // A free on the terminal cycle wins: normal release, no error.
          if (w_owner_free) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= c_gap;
          end else if (w_term) begin
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_err_id      <= r_last_owner;
            r_state       <= c_gap;
          end
        end
        c_gap: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Hold timer: cleared on grant, counts HOLD cycles, stops at the terminal
  // count so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == c_grant) begin
      r_cnt <= '0;
    end else if ((r_state == c_hold) && !w_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign grant       = r_grant;
  assign busy        = r_busy;
  assign word_number = r_word_number;
  assign timeout_err = r_timeout_err;
  assign err_id      = r_err_id;

endmodule

`default_nettype wire

// File: tb/tb_bus_txn_scheduler.sv
// ============================================================================
// Module   : tb_bus_txn_scheduler
// Purpose  : Self-checking bench for bus_txn_scheduler. Expected grants and
//            timeout errors are queued when stimulus is applied and checked
//            by a monitor when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_txn_scheduler;

  localparam int N_REQ   = 3;
  localparam int WN_W    = 4;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WN_W-1:0]  req_words = '0;
  logic [N_REQ-1:0]       free = '0;
  logic [N_REQ-1:0]       grant;
  logic [WN_W-1:0]        word_number;
  logic                   busy;
  logic                   timeout_err;
  logic [1:0]             err_id;

  typedef struct packed {
    logic [2:0] g;
    logic [3:0] w;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] err_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_err_pulses = 0;
  logic [2:0] prev_grant = '0;

  bus_txn_scheduler #(
    .N_REQ   (N_REQ),
    .WN_W    (WN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_words   (req_words),
    .free        (free),
    .grant       (grant),
    .word_number (word_number),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_id      (err_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait for a nonzero grant, counting falling edges; bounded.
  task automatic wait_grant(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while ((grant == 3'b000) && (cycles < budget));
    if (grant == 3'b000) check("wait_grant_expired", 0, 1);
  endtask

  // Scoreboard monitor: compare each new grant and each error pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if ((grant != 3'b000) && (prev_grant == 3'b000)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", grant, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_grant", grant, e.g);
          check("sb_word_number", word_number, e.w);
          check("sb_busy", busy, 1);
        end
      end
      if (timeout_err) begin
        n_err_pulses++;
        if (err_q.size() == 0) check("unexpected_timeout_err", timeout_err, 0);
        else check("sb_err_id", err_id, err_q.pop_front());
      end
    end
    prev_grant = grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int hc;
    logic [2:0] rr_exp [4];
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_word_number", word_number, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_err_id", err_id, 0);
    reset = 1'b0;

    // Single io transaction, 2-cycle latency, free release
    @(negedge clk);
    req = 3'b001; req_words = {4'd0, 4'd0, 4'd4};
    exp_q.push_back('{g: 3'b001, w: 4'd4});
    wait_grant(10, cyc);
    check("s1_latency", cyc, 2);
    req = 3'b000;
    req_words = {4'd0, 4'd0, 4'd9};
    repeat (2) @(negedge clk);
    check("s1_hold_after_req_drop", grant, 3'b001);
    check("s1_word_number_stable", word_number, 4);
    free = 3'b001;
    @(negedge clk);
    free = 3'b000;
    check("s1_gap_grant", grant, 0);
    check("s1_gap_busy", busy, 0);
    @(negedge clk);
    check("s1_idle_grant", grant, 0);
    check("s1_word_hold", word_number, 4);

    // Round-robin with all three requesting
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_words = {4'd7, 4'd5, 4'd3};
    req = 3'b111;
    exp_q.push_back('{g: 3'b001, w: 4'd3});
    exp_q.push_back('{g: 3'b010, w: 4'd5});
    exp_q.push_back('{g: 3'b100, w: 4'd7});
    exp_q.push_back('{g: 3'b001, w: 4'd3});
    for (int i = 0; i < 4; i++) begin
      wait_grant(10, cyc);
      if (i > 0) check("s2_gap_cycles_in_range", (cyc >= 1 && cyc <= 3), 1);
      if (i == 3) req = 3'b000;
      repeat (2) @(negedge clk);
      check("s2_hold_owner", grant, rr_exp[i]);
      free = grant;
      @(negedge clk);
      free = 3'b000;
      check("s2_gap_grant", grant, 0);
    end

    // Timeout on requester 1
    @(negedge clk);
    req = 3'b010; req_words = {4'd0, 4'd6, 4'd0};
    exp_q.push_back('{g: 3'b010, w: 4'd6});
    err_q.push_back(2'd1);
    wait_grant(10, cyc);
    req = 3'b000;
    hc = 1;
    while ((grant != 3'b000) && (hc < 20)) begin
      @(negedge clk);
      if (grant != 3'b000) hc++;
    end
    check("s3_hold_cycles", hc, TIMEOUT);
    check("s3_timeout_err", timeout_err, 1);
    check("s3_err_id", err_id, 1);
    check("s3_busy", busy, 0);
    @(negedge clk);
    check("s3_err_pulse_len", timeout_err, 0);
    check("s3_err_id_hold", err_id, 1);

    // Zero word count never granted (requester 2 first in search order)
    req_words = {4'd0, 4'd2, 4'd0};
    req = 3'b110;
    exp_q.push_back('{g: 3'b010, w: 4'd2});
    wait_grant(10, cyc);
    req = 3'b100;
    @(negedge clk);
    free = 3'b010;
    @(negedge clk);
    free = 3'b000;
    check("s5_gap_grant", grant, 0);
    repeat (6) @(negedge clk);
    check("s5_zero_words_never_granted", grant, 0);
    req = 3'b000;

    // Free coincides with terminal count; non-owner free ignored
    @(negedge clk);
    req = 3'b001; req_words = {4'd0, 4'd0, 4'd9};
    exp_q.push_back('{g: 3'b001, w: 4'd9});
    wait_grant(10, cyc);
    req = 3'b000;
    @(negedge clk);
    free = 3'b100;
    @(negedge clk);
    free = 3'b000;
    check("s4_nonowner_free_ignored", grant, 3'b001);
    repeat (TIMEOUT - 3) @(negedge clk);
    check("s4_hold_at_terminal", grant, 3'b001);
    free = 3'b001;
    @(negedge clk);
    free = 3'b000;
    check("s4_released", grant, 0);
    check("s4_no_timeout_err", timeout_err, 0);
    check("s4_err_id_unchanged", err_id, 1);

    // Reset mid-HOLD
    @(negedge clk);
    req = 3'b100; req_words = {4'd5, 4'd0, 4'd0};
    exp_q.push_back('{g: 3'b100, w: 4'd5});
    wait_grant(10, cyc);
    req = 3'b000;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("s6_async_grant", grant, 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_word_number", word_number, 0);
    check("s6_async_timeout_err", timeout_err, 0);
    check("s6_async_err_id", err_id, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // First request after reset release
    req = 3'b010; req_words = {4'd0, 4'd3, 4'd0};
    exp_q.push_back('{g: 3'b010, w: 4'd3});
    wait_grant(10, cyc);
    check("s7_latency_after_reset", cyc, 2);
    req = 3'b000;
    @(negedge clk);
    free = 3'b010;
    @(negedge clk);
    free = 3'b000;
    repeat (3) @(negedge clk);

    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_err_q_empty", err_q.size(), 0);
    check("end_err_pulse_count", n_err_pulses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
